mem_port_arbiter: RTL

- Shares one single-ported unified memory between two requesters: instruction fetch (from the fetch stage) and data load/store (from the memory stage) of the multicycle core.
- Arbitrates between them round-robin and sequences each access through a fixed settle window of WAIT_CYCLES, matching the memory's buffered read delay.
- Returns registered read data with a one-cycle ack pulse.
- Sits between the control unit / datapath and the memory arrays.

---
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-ported unified memory between instruction fetch and
//   data load/store. Round-robin arbitration on ties, a fixed settle window
//   of WAIT_CYCLES per access, registered read data and one-cycle acks.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   instr_req/addr              fetch request (held until instr_ack)
//   instr_ack/rdata             fetch completion pulse, registered data
//   data_req/we/addr/wdata      load/store request (held until data_ack)
//   data_ack/rdata              load/store completion pulse, registered data
//   misaligned                  pulses with the ack if addr[1:0] != 0
//   busy                        FSM not idle
//   mem_en/we/addr/wdata        memory interface (word-aligned address)
//   mem_rdata                   memory read data, valid after WAIT_CYCLES
module mem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_req,
    input  logic [ADDR_W-1:0] instr_addr,
    output logic              instr_ack,
    output logic [DATA_W-1:0] instr_rdata,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_ack,
    output logic [DATA_W-1:0] data_rdata,
    output logic              misaligned,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    typedef enum logic {
        OWN_INSTR = 1'b0,
        OWN_DATA  = 1'b1
    } owner_t;

    state_t     state;
    owner_t     owner;
    owner_t     last_grant;
    logic [3:0] cnt;
    logic [1:0] addr_lo;
    logic       grant_instr;

    // Instruction wins when it is the only requester, or on a tie when data
    // was the side granted last time.
    always_comb begin
        grant_instr = instr_req && (!data_req || (last_grant == OWN_DATA));
    end

    // mem_addr, mem_wdata and mem_we double as the latched copy of the
    // granted request, so they stay stable for the whole access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= OWN_INSTR;
            last_grant  <= OWN_DATA;
            cnt         <= '0;
            addr_lo     <= '0;
            instr_ack   <= 1'b0;
            instr_rdata <= '0;
            data_ack    <= 1'b0;
            data_rdata  <= '0;
            misaligned  <= 1'b0;
            busy        <= 1'b0;
            mem_en      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            instr_ack  <= 1'b0;
            data_ack   <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_req || data_req) begin
                        if (instr_req && data_req) begin
                            last_grant <= grant_instr ? OWN_INSTR : OWN_DATA;
                        end
                        owner <= grant_instr ? OWN_INSTR : OWN_DATA;
                        if (grant_instr) begin
                            mem_addr  <= {instr_addr[ADDR_W-1:2], 2'b00};
                            addr_lo   <= instr_addr[1:0];
                            mem_wdata <= '0;
                            mem_we    <= 1'b0;
                        end else begin
                            mem_addr  <= {data_addr[ADDR_W-1:2], 2'b00};
                            addr_lo   <= data_addr[1:0];
                            mem_wdata <= data_wdata;
                            mem_we    <= data_we;
                        end
                        mem_en <= 1'b1;
                        cnt    <= CNT_LOAD;
                        busy   <= 1'b1;
                        state  <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt == '0) begin
                        // mem_we is still the latched store flag at this edge;
                        // stores leave data_rdata untouched.
                        if (owner == OWN_INSTR) begin
                            instr_rdata <= mem_rdata;
                        end else if (!mem_we) begin
                            data_rdata <= mem_rdata;
                        end
                        instr_ack  <= (owner == OWN_INSTR);
                        data_ack   <= (owner == OWN_DATA);
                        misaligned <= (addr_lo != 2'b00);
                        mem_en     <= 1'b0;
                        mem_we     <= 1'b0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy   <= 1'b0;
                    mem_en <= 1'b0;
                    mem_we <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
